// File: rtl/mul_issue.sv
// Two-stage issue/capture wrapper around an external N x N unsigned multiplier.
// Stage 1 registers operand magnitudes; stage 2 restores the sign and selects the result half.
module mul_issue #(
    parameter int N     = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [N-1:0]     mul_a,
    output logic [N-1:0]     mul_b,
    input  logic [2*N-1:0]   mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // valid never depends on ready; in_ready may depend on out_ready and flush.

    logic             s1_valid;
    logic             s1_neg;
    logic [1:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;

    logic             sa;
    logic             sb;
    logic [N-1:0]     mag_a;
    logic [N-1:0]     mag_b;
    logic             accept;
    logic             s1_adv;
    logic [2*N-1:0]   prod;
    logic [N-1:0]     result;

    always_comb begin
        sa    = in_a[N-1] & ((in_op == OP_MULH) | (in_op == OP_MULHSU));
        sb    = in_b[N-1] & (in_op == OP_MULH);
        // The most-negative value negates to itself, which is its correct unsigned magnitude.
        mag_a = sa ? -in_a : in_a;
        mag_b = sb ? -in_b : in_b;
    end

    assign s1_adv   = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~flush & (~s1_valid | s1_adv);
    assign accept   = in_valid & in_ready;

    always_comb begin
        prod   = s1_neg ? -mul_p : mul_p;
        result = (s1_op == OP_MUL) ? prod[N-1:0] : prod[2*N-1:N];
    end

    // Stage 1: operand register feeding the multiplier.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_neg   <= 1'b0;
            s1_op    <= 2'b00;
            s1_tag   <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_neg   <= sa ^ sb;
            s1_op    <= in_op;
            s1_tag   <= in_tag;
            mul_a    <= mag_a;
            mul_b    <= mag_b;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: result register presented to writeback; data held during flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (s1_adv) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_tag   <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue: queue scoreboard fed at accept, checked at writeback transfer.
module tb_mul_issue;

    localparam int N     = 16;
    localparam int TAG_W = 5;
    localparam int W     = TAG_W + N;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [2*N-1:0]   mul_p;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    int stalls   = 0;
    int n0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] held;

    mul_issue #(.N(N), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    // Behavioural multiplier standing in for the combinational array.
    assign mul_p = {16'h0, mul_a} * {16'h0, mul_b};

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        logic [63:0] xa, xb, pr;
        xa = (op == 2'd1 || op == 2'd2) ? {{48{a[15]}}, a} : {48'h0, a};
        xb = (op == 2'd1) ? {{48{b[15]}}, b} : {48'h0, b};
        pr = xa * xb;
        return (op == 2'd0) ? pr[15:0] : pr[31:16];
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Drives one request starting just after a posedge; returns just after its accept edge.
    task automatic issue(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [TAG_W-1:0] tag, input logic [N-1:0] exp);
        bit done = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        for (int w = 0; w < 20 && !done; w++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({tag, exp});
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL issue_timeout observed=in_ready_low expected=accept");
        end
        in_valid = 1'b0;
    endtask

    task automatic issue_m(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [TAG_W-1:0] tag);
        issue(op, a, b, tag, model(op, a, b));
    endtask

    task automatic drain();
        for (int w = 0; w < 60 && exp_q.size() != 0; w++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;

        // Scoreboard monitor: every writeback transfer pops and compares one expectation.
        fork
            forever begin
                logic [W-1:0] e;
                @(negedge clk);
                if (out_valid && out_ready) begin
                    n_out++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $error("FAIL unexpected_output observed=%0h expected=none",
                               {out_tag, out_data});
                    end else begin
                        e = exp_q.pop_front();
                        check("result", {out_tag, out_data}, e);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_a", mul_a, 0);
        check("rst_mul_b", mul_b, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        @(posedge clk);
        #1;

        // First-transaction latency
        out_ready = 1'b1;
        issue(2'd0, 16'd3, 16'd5, 5'd7, 16'h000F);
        @(negedge clk);
        check("lat_s1_out_valid", out_valid, 0);
        check("lat_mul_a", mul_a, 3);
        check("lat_mul_b", mul_b, 5);
        @(negedge clk);
        check("lat_out_valid", out_valid, 1);
        check("lat_out_data", out_data, 16'h000F);
        check("lat_out_tag", out_tag, 7);
        @(posedge clk);
        #1;

        // Sign handling corner cases
        issue(2'd1, 16'hFFFE, 16'h0003, 5'd1, 16'hFFFF);
        issue(2'd1, 16'h8000, 16'h8000, 5'd2, 16'h4000);
        issue(2'd3, 16'hFFFF, 16'hFFFF, 5'd3, 16'hFFFE);
        issue(2'd2, 16'hFFFF, 16'hFFFF, 5'd4, 16'hFFFF);
        issue(2'd0, 16'hFFFF, 16'hFFFF, 5'd5, 16'h0001);
        drain();

        // Back-to-back random stream at full throughput
        stalls = 0;
        n0 = n_out;
        for (int i = 0; i < 8; i++)
            issue_m(2'($urandom_range(0, 3)), 16'($urandom_range(0, 65535)),
                    16'($urandom_range(0, 65535)), 5'(i + 8));
        @(negedge clk);
        @(negedge clk);
        #1;
        check("stream_results", n_out, n0 + 8);
        check("stream_stalls", stalls, 0);
        check("stream_queue", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Backpressure: two requests fill the pipe, the third waits
        out_ready = 1'b0;
        issue_m(2'd1, 16'h8001, 16'h1234, 5'd20);
        issue_m(2'd2, 16'hF00F, 16'hABCD, 5'd21);
        held = exp_q[0];
        in_valid = 1'b1; in_op = 2'd0; in_a = 16'h0101; in_b = 16'h0202; in_tag = 5'd22;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_stable", {out_tag, out_data}, held);
        end
        check("bp_queue", exp_q.size(), 2);
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        exp_q.push_back({5'd22, model(2'd0, 16'h0101, 16'h0202)});
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Flush with both stages full
        out_ready = 1'b0;
        issue_m(2'd3, 16'h4321, 16'h8765, 5'd9);
        issue_m(2'd0, 16'h00FF, 16'h0011, 5'd10);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 2'd0; in_a = 16'h0005; in_b = 16'h0006; in_tag = 5'd30;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        check("flush_ready_after", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        check("flush_no_stale", out_valid, 0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue_m(2'd3, 16'h1234, 16'h5678, 5'd11);
        @(negedge clk);
        check("flush_lat_s1", out_valid, 0);
        @(negedge clk);
        check("flush_lat_out", out_valid, 1);
        drain();

        // Reset one cycle after an accept discards the request
        issue_m(2'd0, 16'd7, 16'd9, 5'd12);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("rst2_out_valid", out_valid, 0);
        check("rst2_mul_a", mul_a, 0);
        check("rst2_mul_b", mul_b, 0);
        check("rst2_out_data", out_data, 0);
        check("rst2_out_tag", out_tag, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst2_no_output", out_valid, 0);
        end
        check("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
Name: mul_issue

Overview:
- Sequential issue/capture stage wrapped around the combinational N×N unsigned array multiplier in the CPU execute path.
- Upstream side:
  - accepts RISC-V-style multiply requests with a valid/ready handshake;
  - converts signed operands to magnitudes;
  - registers the magnitudes and drives them to the multiplier.
- Downstream side:
  - captures the 2N-bit unsigned product;
  - restores the sign and selects the low or high half;
  - presents an N-bit tagged result to writeback with valid/ready.
- Two-stage pipeline, full throughput, backpressure-safe.

Parameters:
- N, 16, operand and result width; the multiplier instance is N×N→2N.
- TAG_W, 5, width of the destination-register tag carried alongside each request.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous pipeline kill; the active-high pulse clears both stages.
- in_valid  in  1  request valid.
- in_ready  out  1  stage can accept the request this cycle.
- in_op  in  2  operation: 00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high).
- in_a  in  N  operand A (rs1).
- in_b  in  N  operand B (rs2).
- in_tag  in  TAG_W  destination tag.
- mul_a  out  N  magnitude of A to the multiplier input1.
- mul_b  out  N  magnitude of B to the multiplier input2.
- mul_p  in  2N  unsigned product returned by the multiplier, combinational from mul_a/mul_b.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_data  out  N  result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset (rst=1 at an edge):
  - s1_valid=0, out_valid=0.
  - mul_a=0, mul_b=0, out_data=0, out_tag=0, all internal op/sign registers 0.
  - rst has priority over flush and every handshake; an in-flight request is discarded and never appears at the output.
- Flush:
  - Same as reset for s1_valid and out_valid only; data registers are held.
  - A request presented in the flush cycle is not accepted; in_ready is 0 while flush=1.
- Sign handling at accept:
  - sa = in_a[N-1] when op∈{01,10}, else 0.
  - sb = in_b[N-1] when op=01, else 0.
  - mag_a = sa ? (~in_a+1) : in_a, computed in N bits; same rule gives mag_b.
  - The most-negative value 2^(N-1) maps to magnitude 2^(N-1), which is correct as unsigned.
  - neg = sa ^ sb.
- Stage 1 (operand register):
  - Accept = in_valid & in_ready.
  - On accept it loads mul_a=mag_a, mul_b=mag_b, neg, op, tag and sets s1_valid.
  - mul_a/mul_b hold their value while s1_valid is 1 and not advancing.
- Stage 2 (result register):
  - s1_adv = s1_valid & (~out_valid | out_ready).
  - On s1_adv: p = neg ? (~mul_p+1) : mul_p, in 2N bits.
  - out_data = (op==00) ? p[N-1:0] : p[2N-1:N].
  - out_tag is loaded and out_valid is set.
  - s1_valid clears on s1_adv unless a new accept happens in the same cycle.
  - out_valid clears when out_ready=1 and there is no s1_adv.
- in_ready = ~flush & (~s1_valid | s1_adv), combinational.
- Latency: a request accepted at edge k gives out_valid=1 after edge k+1.
- Throughput: one result per cycle with out_ready held high.
- Stall: with out_ready=0 the pipeline holds at most 2 requests. out_data and out_tag stay stable while out_valid=1 and out_ready=0.
- Simultaneous accept and advance in one cycle is legal; the stage 1 contents are replaced, with no bubble.
- All arithmetic is modulo 2^(2N); there are no overflow flags.

Test Plan:
- Reset, then MUL a=3 b=5 tag=7 with out_ready=1 → out_valid 2 edges after accept, out_data=0x000F, out_tag=7.
- Sign cases with N=16:
  - MULH 0xFFFE×0x0003 → 0xFFFF.
  - MULH 0x8000×0x8000 → 0x4000.
  - MULHU 0xFFFF×0xFFFF → 0xFFFE.
  - MULHSU 0xFFFF×0xFFFF → 0xFFFF.
  - MUL 0xFFFF×0xFFFF → 0x0001.
- Back-to-back stream of 8 random ops with out_ready=1 → in_ready stays 1; every result matches a golden 32-bit model; one result per cycle, in order.
- Backpressure: hold out_ready=0 and issue 3 requests → exactly 2 accepted, in_ready=0 on the 3rd, out_data/out_tag stable. Release out_ready → 3rd accepted the next cycle; order is preserved.
- flush with both stages full → out_valid=0 and s1_valid=0 next cycle; a request presented during flush is not accepted; the next request completes with latency 2.
- rst asserted one cycle after an accept → no result ever emitted; all outputs 0; in_ready=1 after rst deasserts.
